// File: rtl/decoder_scan_if.sv
// Bundle of the decoder_scan control inputs and registered outputs.
// The master drives en/mode/dir/sel; the slave (the decoder) drives out/idx/wrap/cnt.
interface decoder_scan_if #(
    parameter int N   = 4,
    parameter int DIV = 4
);
    localparam int OW = 1 << N;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    // Handshake-free bus: inputs are sampled on every rising clk edge, and outputs
    // are valid from #1 after that edge until the next one.
    logic          en;
    logic          mode;
    logic          dir;
    logic [N-1:0]  sel;
    logic [OW-1:0] out;
    logic [N-1:0]  idx;
    logic          wrap;
    logic [CW-1:0] cnt;

    modport master (
        output en, mode, dir, sel,
        input  out, idx, wrap, cnt
    );

    modport slave (
        input  en, mode, dir, sel,
        output out, idx, wrap, cnt
    );
endinterface

// File: rtl/decoder_scan.sv
// N-to-2**N registered decoder with a direct-select mode and a prescaled
// walking-one scan mode. The prescaler count is exported on the bus for observation.
module decoder_scan #(
    parameter int N   = 4,
    parameter int DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    decoder_scan_if.slave bus
);
    localparam int              OW      = 1 << N;
    localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [N-1:0]    IDX_ONE = N'(1);
    localparam logic [N-1:0]    IDX_MAX = '1;
    localparam logic [OW-1:0]   OUT_B0  = OW'(1);

    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic [OW-1:0] out_q, out_d;

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!bus.mode) begin
            idx_d = bus.sel;
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (bus.dir) begin
                idx_d  = idx_q - IDX_ONE;
                wrap_d = (idx_q == '0);
            end else begin
                idx_d  = idx_q + IDX_ONE;
                wrap_d = (idx_q == IDX_MAX);
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        // Decode the next index so out and idx always change on the same edge.
        out_d = bus.en ? (OUT_B0 << idx_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            out_q  <= OUT_B0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            out_q  <= out_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
    assign bus.cnt  = cnt_q;
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 4: select width; output width is 2**N; legal range 1..8.
REQ-002 Parameter DIV, default 4: scan prescaler period in clock cycles; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  output enable; 0 forces out to all zeros.
REQ-006 mode  input  1  0 = direct decode of sel; 1 = auto-scan (walking one).
REQ-007 dir  input  1  scan direction; 0 = up (index+1), 1 = down (index-1); ignored in direct mode.
REQ-008 sel  input  N  decode address, used in direct mode.
REQ-009 out  output  2**N  registered one-hot (or all-zero) decode output.
REQ-010 idx  output  N  registered current index; out bit idx is the active bit when en=1.
REQ-011 wrap  output  1  registered one-cycle pulse on a scan wrap-around.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 Internal prescaler counter cnt SHALL be ceil(log2(DIV)) bits wide (minimum 1 bit) and count 0..DIV-1.
REQ-014 Direct mode (mode=0): each cycle idx <= sel and cnt <= 0; one-cycle latency from sel to idx/out.
REQ-015 Scan mode (mode=1): when cnt < DIV-1, cnt increments and idx holds; when cnt == DIV-1, cnt <= 0 and idx steps by one in direction dir.
REQ-016 Scan stepping SHALL wrap modulo 2**N: up from 2**N-1 to 0; down from 0 to 2**N-1.
REQ-017 wrap SHALL be 1 for exactly the cycle in which idx holds the wrapped value; otherwise 0; always 0 in direct mode.
REQ-018 DIV=1 SHALL step idx on every scan-mode cycle.
REQ-019 en=1: out SHALL equal the one-hot encoding of the next-state idx, registered in the same edge (out always matches idx, 0 latency between them).
REQ-020 en=0: out <= 0 on the next edge; idx, cnt and wrap logic SHALL continue to update as if en=1 (the scan keeps running in the dark).
REQ-021 Mode change 0->1: scan starts from the current idx with cnt=0; first step occurs DIV cycles after the mode edge is sampled.
REQ-022 Mode change 1->0: the next edge loads sel, discarding the partial prescaler count.
REQ-023 A dir change mid-period SHALL take effect on the next step; cnt is not reset.
REQ-024 out SHALL never have more than one bit set in any cycle.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force idx=0, cnt=0, wrap=0, out=1 (bit 0 set), regardless of en.
REQ-026 On rst deassertion, the first rising edge SHALL apply normal Function rules from the reset state.
REQ-027 rst asserted mid-scan SHALL abandon the current prescaler period; scanning resumes from idx=0, cnt=0.

Verification (N=4, DIV=4 unless stated)
REQ-028 Direct sweep: mode=0, en=1, sel=0..15 one per cycle -> one cycle later out = 1<<sel, idx=sel, wrap=0 throughout.
REQ-029 Scan up with wrap: mode=1, dir=0, start idx=14 -> idx 14,15 each held 4 cycles, then idx=0 with wrap=1 for one cycle, out=16'h0001.
REQ-030 Scan down with DIV=1: start idx=1, dir=1 -> idx 1,0,15,14 on consecutive cycles; wrap=1 only on the cycle idx=15.
REQ-031 Enable gating: scanning with en=0 for 8 cycles -> out=0 throughout; idx advances by 2; re-assert en -> out = one-hot of idx on the next edge.
REQ-032 Async reset mid-scan: assert rst between clock edges at idx=9 -> out=16'h0001, idx=0, wrap=0 before the next edge; after release, first step occurs 4 cycles later.
REQ-033 Mode switch: scan at idx=5 with cnt=2, set mode=0 with sel=12 -> next edge idx=12, out=16'h1000; return to mode=1 -> idx=13 four cycles later.
